// File: rtl/fetch_prefetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_prefetch_unit_pkg
// Purpose  : Shared widths and defaults for the fetch/prefetch core and benches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_prefetch_unit_pkg;

    localparam int c_WORD        = 32;
    localparam int c_ADDR        = 16;
    localparam int c_FETCH_DEPTH = 4;
    localparam int c_IMEM_LAT    = 1;

    // Wide enough to hold queue count + in-flight reads + one pop credit.
    function automatic int occ_width(input int depth, input int lat);
        return $clog2(depth + lat + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Prefetch queue; push/pop/flush, element count and head output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int DATA_W = c_WORD + c_ADDR,
    parameter int DEPTH  = c_FETCH_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_head,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    // Head reads as zero while empty so stale entries never reach decode.
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(i_push && !i_flush && w_full && !w_do_pop));

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
// ============================================================================
// Module   : fetch_prefetch_unit
// Purpose  : Sequential instruction prefetch with credit-based issue, latency
//            tracking line, prefetch queue and branch flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int              WORD       = c_WORD,
    parameter int              ADDR       = c_ADDR,
    parameter int              DEPTH      = c_FETCH_DEPTH,
    parameter int              MEM_LAT    = c_IMEM_LAT,
    parameter logic [ADDR-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [ADDR-1:0] next_addr,
    output logic            rd_en_o,
    input  logic [WORD-1:0] inst_i,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    output logic            v_o,
    input  logic            stall_i,
    output logic            stall_o,
    input  logic            branch,
    input  logic [ADDR-1:0] branch_addr
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_OCC_W = occ_width(DEPTH, MEM_LAT);

    logic [ADDR-1:0]      r_pc;
    logic [MEM_LAT-1:0]   r_inf_v;
    logic [ADDR-1:0]      r_inf_pc [MEM_LAT];

    logic [MEM_LAT-1:0]   w_inf_shift;
    logic [c_OCC_W-1:0]   w_inflight;
    logic [c_OCC_W-1:0]   w_occ;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_can_issue;
    logic [WORD+ADDR-1:0] w_head;

    assign w_pop = w_valid & ~stall_i & ~branch;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_inf_v[i]);
        end
    end

    // The read landing this edge is still counted, so a pop is the only
    // thing that can free a credit in the current cycle.
    assign w_occ       = c_OCC_W'(w_count) + w_inflight;
    assign w_can_issue = (w_occ < (c_OCC_W'(DEPTH) + c_OCC_W'(w_pop)));

    assign next_addr = r_pc;
    assign rd_en_o   = w_can_issue & ~branch & reset;
    assign stall_o   = ~w_can_issue & ~branch & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_ADDR;
        end else if (branch) begin
            r_pc <= branch_addr;
        end else if (rd_en_o) begin
            r_pc <= r_pc + ADDR'(1);
        end
    end

    if (MEM_LAT == 1) begin : g_lat_one
        assign w_inf_shift = rd_en_o;
    end else begin : g_lat_multi
        assign w_inf_shift = {r_inf_v[MEM_LAT-2:0], rd_en_o};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inf_v <= '0;
        end else if (branch) begin
            r_inf_v <= '0;
        end else begin
            r_inf_v <= w_inf_shift;
        end
    end

    // Address tags travel alongside the valid bits; only the valid bits matter.
    always_ff @(posedge clk) begin
        r_inf_pc[0] <= r_pc;
        for (int i = 1; i < MEM_LAT; i++) begin
            r_inf_pc[i] <= r_inf_pc[i-1];
        end
    end

    fetch_fifo #(
        .DATA_W (WORD + ADDR),
        .DEPTH  (DEPTH),
        .CNT_W  (c_CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inf_v[MEM_LAT-1]),
        .i_data  ({inst_i, r_inf_pc[MEM_LAT-1]}),
        .i_pop   (w_pop),
        .i_flush (branch),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign v_o    = w_valid;
    assign inst_o = w_head[WORD+ADDR-1:ADDR];
    assign pc_o   = w_head[ADDR-1:0];

endmodule

`default_nettype wire
